alu_result_buffer: RTL and testbench

- Capture-side counterpart to the operand path: operands are written into operand memories and consumed by the ALU, and this block receives each ALU result (data plus carry) and queues it.
- Results are handed to a downstream reader over a valid/ready handshake.
- Sits directly after the ALU output, one instance per datapath.
- Storage is a circular FIFO of 2^address entries with first-word-fall-through read presentation.

---
 rtl/alu_result_buffer.sv | 65 ++++++
 tb/tb_alu_result_buffer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: first-word-fall-through FIFO that queues ALU result words with their carries
module alu_result_buffer #(
   parameter int data_width = 8,
   parameter int address = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [data_width-1:0] d_in,
   input  logic                  c_in,
   input  logic                  rd_ready,
   output logic                  rd_valid,
   output logic [data_width-1:0] q_out,
   output logic                  c_out,
   output logic                  full,
   output logic                  empty,
   output logic [address:0]      count,
   output logic                  overflow
);
   logic [data_width:0]  mem_q [2**address];
   logic [address-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [address:0]     count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic                 push, pop;
   logic [data_width:0]  head;
   // Flags and head presentation come only from registered state; count can only reach 2^address when its top bit is set
   always_comb begin
      empty    = (count_q == '0);
      full     = count_q[address];
      rd_valid = ~empty;
      head     = mem_q[rd_ptr_q];
      q_out    = empty ? '0 : head[data_width-1:0];
      c_out    = empty ? 1'b0 : head[data_width];
      count    = count_q;
      overflow = overflow_q;
   end
   // A push into a full buffer is still taken when the head leaves in the same cycle, since it lands in the freed slot
   always_comb begin
      pop        = rd_valid & rd_ready;
      push       = wr_en & (~full | pop);
      wr_ptr_d   = push ? wr_ptr_q + address'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + address'(1) : rd_ptr_q;
      count_d    = (push & ~pop) ? count_q + (address+1)'(1) :
                   (pop & ~push) ? count_q - (address+1)'(1) : count_q;
      overflow_d = overflow_q | (wr_en & ~push);
   end
   // Pointer, occupancy and sticky overflow registers; reset wins over any same-cycle traffic
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end
   // Storage keeps the carry alongside its data word; contents need no reset
   always_ff @(posedge clk) begin
      if (push & ~rst) mem_q[wr_ptr_q] <= {c_in, d_in};
   end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: vector table, directed corner sequences and randomized traffic against a queue model
module tb_alu_result_buffer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] d_in = '0;
   logic       c_in = 1'b0;
   logic       rd_ready = 1'b0;
   logic       rd_valid, c_out, full, empty, overflow;
   logic [7:0] q_out;
   logic [4:0] count;

   int tests = 0;
   int fails = 0;

   logic [8:0] mq[$];
   bit         movf = 1'b0;

   always #5 clk = ~clk;

   alu_result_buffer #(.data_width(8), .address(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .d_in(d_in), .c_in(c_in), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .q_out(q_out), .c_out(c_out), .full(full), .empty(empty),
      .count(count), .overflow(overflow)
   );

   typedef struct {
      logic       r, w;
      logic [7:0] d;
      logic       c, rr;
      int         e_count;
      logic       e_valid;
      logic [7:0] e_q;
      logic       e_c, e_full, e_ovf;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      int n;
      n = mq.size();
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == 16));
      chk("rd_valid", 32'(rd_valid), 32'(n != 0));
      chk("q_out", 32'(q_out), n != 0 ? 32'(mq[0][7:0]) : 32'd0);
      chk("c_out", 32'(c_out), n != 0 ? 32'(mq[0][8]) : 32'd0);
      chk("overflow", 32'(overflow), 32'(movf));
   endtask

   task automatic tick(input logic r, input logic w, input logic [7:0] d, input logic c, input logic rr);
      bit p, q;
      @(negedge clk);
      rst = r; wr_en = w; d_in = d; c_in = c; rd_ready = rr;
      @(posedge clk);
      if (r) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         p = (mq.size() != 0) && rr;
         q = w && (mq.size() < 16 || p);
         if (p) void'(mq.pop_front());
         if (q) mq.push_back({c, d});
         if (w && !q) movf = 1'b1;
      end
      #1;
      cmp_model();
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         tick(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].c, tbl[i].rr);
         chk("tbl_count", 32'(count), 32'(tbl[i].e_count));
         chk("tbl_valid", 32'(rd_valid), 32'(tbl[i].e_valid));
         chk("tbl_q", 32'(q_out), 32'(tbl[i].e_q));
         chk("tbl_c", 32'(c_out), 32'(tbl[i].e_c));
         chk("tbl_full", 32'(full), 32'(tbl[i].e_full));
         chk("tbl_ovf", 32'(overflow), 32'(tbl[i].e_ovf));
      end
      // fill to full, then simultaneous push+pop while full
      for (int i = 1; i <= 16; i++) tick(1'b0, 1'b1, 8'(i), 1'(i % 2), 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd16);
      chk("fill_head", 32'(q_out), 32'h01);
      tick(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
      chk("simul_count", 32'(count), 32'd16);
      chk("simul_ovf", 32'(overflow), 32'd0);
      chk("simul_head", 32'(q_out), 32'h02);
      for (int k = 0; k < 16; k++) begin
         chk("simul_drain", 32'(q_out), k < 15 ? 32'(k + 2) : 32'h55);
         tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      end
      chk("simul_empty", 32'(empty), 32'd1);
      // refill, then overflow with a dropped push
      for (int i = 1; i <= 16; i++) tick(1'b0, 1'b1, 8'(i), 1'(i % 2), 1'b0);
      tick(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      for (int k = 0; k < 16; k++) begin
         chk("ovf_drain_q", 32'(q_out), 32'(k + 1));
         chk("ovf_drain_c", 32'(c_out), 32'((k + 1) % 2));
         tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      end
      chk("ovf_sticky", 32'(overflow), 32'd1);
      chk("drained_empty", 32'(empty), 32'd1);
      chk("drained_q", 32'(q_out), 32'd0);
      tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("ovf_cleared", 32'(overflow), 32'd0);
      // empty with push and ready: push only, then pop; wraps pointers
      for (int k = 0; k < 40; k++) begin
         tick(1'b0, 1'b1, 8'h3C, 1'(k % 2), 1'b1);
         chk("wrap_valid", 32'(rd_valid), 32'd1);
         chk("wrap_count", 32'(count), 32'd1);
         chk("wrap_q", 32'(q_out), 32'h3C);
         tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
         chk("wrap_popped", 32'(count), 32'd0);
      end
      // mid-stream reset with traffic
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
      chk("mid_count5", 32'(count), 32'd5);
      tick(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_empty", 32'(empty), 32'd1);
      tick(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
      chk("mid_head", 32'(q_out), 32'h77);
      chk("mid_count1", 32'(count), 32'd1);
      // randomized traffic with write-heavy and read-heavy phases
      for (int k = 0; k < 3000; k++) begin
         logic r, w, c, rr;
         logic [7:0] d;
         r  = ($urandom_range(0, 299) == 0);
         w  = ($urandom_range(0, 99) < (((k / 300) % 2) ? 35 : 75));
         rr = ($urandom_range(0, 99) < (((k / 300) % 2) ? 75 : 35));
         d  = 8'($urandom);
         c  = 1'($urandom);
         tick(r, w, d, c, rr);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
